// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry, word widths and draw-engine state encoding
// shared by the rectangle writer and the VGA scan-out reader.
package fb_pkg;
    localparam int FB_WIDTH  = 160;
    localparam int FB_HEIGHT = 120;
    localparam int FB_WORDS  = FB_WIDTH * FB_HEIGHT;
    localparam int ADDR_W    = 15;
    localparam int COLOR_W   = 24;

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_DRAW, ST_DONE} draw_state_t;

    // y*160 as (y<<7)+(y<<5) so no multiplier is inferred.
    function automatic logic [ADDR_W-1:0] row_base_of(input logic [6:0] y);
        return ({8'd0, y} << 7) + ({8'd0, y} << 5);
    endfunction
endpackage

// File: rtl/fb_rect_writer_if.sv
// fb_rect_writer_if: command handshake plus framebuffer write port.
//   master: game-logic side (drives cmd_*, draw_enable; observes writes/status)
//   slave : draw-engine side
interface fb_rect_writer_if;
    import fb_pkg::*;
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_clear;
    logic [7:0]         cmd_x0;
    logic [6:0]         cmd_y0;
    logic [7:0]         cmd_w;
    logic [6:0]         cmd_h;
    logic [COLOR_W-1:0] cmd_color;
    logic               draw_enable;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [COLOR_W-1:0] wr_data;
    logic               busy;
    logic               done;

    modport master (
        output cmd_valid, cmd_clear, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, draw_enable,
        input  cmd_ready, wr_en, wr_addr, wr_data, busy, done
    );
    modport slave (
        input  cmd_valid, cmd_clear, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, draw_enable,
        output cmd_ready, wr_en, wr_addr, wr_data, busy, done
    );
endinterface

// File: rtl/fb_rect_clip.sv
// fb_rect_clip: clip a rectangle command to the frame.
//   in : clear, x0, y0, w, h
//   out: xs/ys (start corner), xe/ye (exclusive end), empty (nothing to draw)
module fb_rect_clip
    import fb_pkg::*;
(
    input  logic       clear,
    input  logic [7:0] x0,
    input  logic [6:0] y0,
    input  logic [7:0] w,
    input  logic [6:0] h,
    output logic [7:0] xs,
    output logic [6:0] ys,
    output logic [7:0] xe,
    output logic [6:0] ye,
    output logic       empty
);
    // 9-bit sums: x0+w can reach 510, which must still compare above the frame width.
    logic [8:0] xsum, ysum;

    always_comb begin
        xsum  = {1'b0, x0} + {1'b0, w};
        ysum  = {2'b0, y0} + {2'b0, h};
        xs    = clear ? 8'd0 : x0;
        ys    = clear ? 7'd0 : y0;
        xe    = clear ? 8'(FB_WIDTH) : 8'(xsum > 9'(FB_WIDTH) ? 9'(FB_WIDTH) : xsum);
        ye    = clear ? 7'(FB_HEIGHT) : 7'(ysum > 9'(FB_HEIGHT) ? 9'(FB_HEIGHT) : ysum);
        empty = !clear && (w == 8'd0 || h == 7'd0 || x0 >= 8'(FB_WIDTH) || y0 >= 7'(FB_HEIGHT));
    end
endmodule

// File: rtl/fb_rect_writer.sv
// fb_rect_writer: rectangle-fill / frame-clear draw engine on the framebuffer write port.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of fb_rect_writer_if (cmd handshake, draw_enable gate,
//              wr_en/wr_addr/wr_data write port, busy/done status)
module fb_rect_writer
    import fb_pkg::*;
(
    input logic             clk,
    input logic             rst,
    fb_rect_writer_if.slave bus
);
    draw_state_t       state;
    logic              lat_clear;
    logic [7:0]        lat_x0, lat_w;
    logic [6:0]        lat_y0, lat_h;
    logic [7:0]        xs, xe, x, x_start, x_end;
    logic [6:0]        ys, ye, y, y_end;
    logic              empty;
    logic [ADDR_W-1:0] row_base;

    fb_rect_clip u_clip (
        .clear (lat_clear),
        .x0    (lat_x0),
        .y0    (lat_y0),
        .w     (lat_w),
        .h     (lat_h),
        .xs    (xs),
        .ys    (ys),
        .xe    (xe),
        .ye    (ye),
        .empty (empty)
    );

    // Stalls are immediate: a low draw_enable suppresses the strobe in the same cycle.
    assign bus.wr_en = (state == ST_DRAW) && bus.draw_enable;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            bus.cmd_ready <= 1'b1;
            bus.wr_addr   <= '0;
            bus.wr_data   <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (bus.cmd_valid) begin
                    lat_clear     <= bus.cmd_clear;
                    lat_x0        <= bus.cmd_x0;
                    lat_y0        <= bus.cmd_y0;
                    lat_w         <= bus.cmd_w;
                    lat_h         <= bus.cmd_h;
                    bus.wr_data   <= bus.cmd_color;
                    bus.cmd_ready <= 1'b0;
                    bus.busy      <= 1'b1;
                    state         <= ST_SETUP;
                end
                ST_SETUP: begin
                    x           <= xs;
                    y           <= ys;
                    x_start     <= xs;
                    x_end       <= xe;
                    y_end       <= ye;
                    row_base    <= row_base_of(ys);
                    bus.wr_addr <= row_base_of(ys) + {7'd0, xs};
                    bus.done    <= empty;
                    state       <= empty ? ST_DONE : ST_DRAW;
                end
                ST_DRAW: if (bus.draw_enable) begin
                    if (x == x_end - 8'd1) begin
                        if (y == y_end - 7'd1) begin
                            bus.done <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            x           <= x_start;
                            y           <= y + 7'd1;
                            row_base    <= row_base + 15'(FB_WIDTH);
                            bus.wr_addr <= row_base + 15'(FB_WIDTH) + {7'd0, x_start};
                        end
                    end else begin
                        x           <= x + 8'd1;
                        bus.wr_addr <= bus.wr_addr + 15'd1;
                    end
                end
                default: begin
                    bus.done      <= 1'b0;
                    bus.busy      <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fb_rect_writer.sv
// tb_fb_rect_writer: randomized self-checking bench; the reference model lists the
// expected framebuffer addresses from clipped rectangle arithmetic and predicts
// the per-cycle strobe/done timing from the draw_enable pattern it applies.
module tb_fb_rect_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    fb_rect_writer_if bus ();

    fb_rect_writer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic scramble_cmd();
        bus.cmd_clear = 1'($urandom);
        bus.cmd_x0    = 8'($urandom);
        bus.cmd_y0    = 7'($urandom);
        bus.cmd_w     = 8'($urandom);
        bus.cmd_h     = 7'($urandom);
        bus.cmd_color = 24'($urandom);
    endtask

    // mode 0: draw_enable always high; 1: random stalls; 2: 5-cycle stall after the 2nd write
    task automatic run_cmd(input logic clr, input logic [7:0] x0, input logic [6:0] y0,
                           input logic [7:0] w, input logic [6:0] h, input logic [23:0] col,
                           input int mode);
        int exp_addr[$];
        int xe, ye, n, mw, c, hold;
        logic de, exp_we, exp_done;
        if (clr) begin
            for (int a = 0; a < 160 * 120; a++) exp_addr.push_back(a);
        end else begin
            xe = (int'(x0) + int'(w) > 160) ? 160 : int'(x0) + int'(w);
            ye = (int'(y0) + int'(h) > 120) ? 120 : int'(y0) + int'(h);
            for (int yy = int'(y0); yy < ye; yy++)
                for (int xx = int'(x0); xx < xe; xx++)
                    exp_addr.push_back(yy * 160 + xx);
        end
        n = exp_addr.size();
        chk("ready_before_cmd", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_clear = clr;
        bus.cmd_x0    = x0;
        bus.cmd_y0    = y0;
        bus.cmd_w     = w;
        bus.cmd_h     = h;
        bus.cmd_color = col;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        mw   = 0;
        c    = 0;
        hold = 0;
        do begin
            @(negedge clk);
            c++;
            de = (mode == 1) ? ($urandom_range(0, 3) != 0) : (hold == 0);
            if (hold > 0) hold--;
            bus.draw_enable = de;
            if (c == 1) begin
                bus.cmd_valid = 1'b0;
                scramble_cmd();
            end
            #1;
            exp_we   = (c >= 2) && (mw < n) && de;
            exp_done = (c >= 2) && (mw == n);
            chk("wr_en", 32'(bus.wr_en), 32'(exp_we));
            chk("done", 32'(bus.done), 32'(exp_done));
            chk("busy", 32'(bus.busy), 32'd1);
            chk("ready_busy", 32'(bus.cmd_ready), 32'd0);
            if (exp_we) begin
                chk("wr_addr", 32'(bus.wr_addr), 32'(exp_addr[mw]));
                chk("wr_data", 32'(bus.wr_data), 32'(col));
                mw++;
                if (mode == 2 && mw == 2) hold = 5;
            end
        end while (!exp_done);
        @(negedge clk);
        bus.draw_enable = 1'b1;
        #1;
        chk("busy_after_done", 32'(bus.busy), 32'd0);
        chk("ready_after_done", 32'(bus.cmd_ready), 32'd1);
        chk("done_single", 32'(bus.done), 32'd0);
        chk("wr_en_idle", 32'(bus.wr_en), 32'd0);
    endtask

    task automatic reset_mid_clear();
        bus.cmd_clear   = 1'b1;
        bus.cmd_color   = 24'h123456;
        bus.cmd_valid   = 1'b1;
        bus.draw_enable = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 101; c++) begin
            @(negedge clk);
            if (c == 1) bus.cmd_valid = 1'b0;
        end
        @(negedge clk);
        #1;
        chk("wr_en_pre_rst", 32'(bus.wr_en), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk("no_done_after_rst", 32'(bus.done), 32'd0);
            chk("idle_after_rst", 32'(bus.wr_en), 32'd0);
        end
    endtask

    initial begin
        bus.cmd_valid   = 1'b0;
        bus.draw_enable = 1'b1;
        scramble_cmd();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_ready", 32'(bus.cmd_ready), 32'd1);
        chk("reset_wr_en", 32'(bus.wr_en), 32'd0);
        chk("reset_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("reset_wr_data", 32'(bus.wr_data), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run_cmd(1'b0, 8'd5, 7'd2, 8'd1, 7'd1, 24'hFF0000, 0);
        run_cmd(1'b0, 8'd158, 7'd118, 8'd4, 7'd4, 24'($urandom), 0);
        run_cmd(1'b1, 8'($urandom), 7'($urandom), 8'($urandom), 7'($urandom), 24'h000000, 0);
        run_cmd(1'b0, 8'd10, 7'd0, 8'd3, 7'd2, 24'($urandom), 2);
        run_cmd(1'b0, 8'd160, 7'($urandom_range(0, 119)), 8'd5, 7'd5, 24'($urandom), 0);
        run_cmd(1'b0, 8'($urandom_range(0, 159)), 7'($urandom_range(0, 119)), 8'd0, 7'd3, 24'($urandom), 0);
        run_cmd(1'b0, 8'd20, 7'd119, 8'd255, 7'd127, 24'($urandom), 0);
        run_cmd(1'b0, 8'd30, 7'd120, 8'd4, 7'd4, 24'($urandom), 0);
        for (int i = 0; i < 25; i++)
            run_cmd(1'b0, 8'($urandom_range(0, 170)), 7'($urandom_range(0, 127)),
                    8'($urandom_range(0, 40)), 7'($urandom_range(0, 30)), 24'($urandom), 1);
        reset_mid_clear();
        run_cmd(1'b0, 8'd100, 7'd50, 8'd7, 7'd3, 24'hABCDEF, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
